// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared sizes and one-hot FSM encodings for the FIR coefficient arbiter
package filter_pkg;

  localparam int PTR   = 9;
  localparam int WIDTH = 16;
  localparam int TAPS  = 512;

  localparam int LOAD_ID        = 0;
  localparam int COMMIT_WAIT_ID = 1;
  localparam int COPY_ID        = 2;
  localparam int N_STATES       = 3;

  typedef logic [N_STATES-1:0] state_t;

  // All-zero is the reset-only encoding; it always steps to LOAD once reset is released.
  localparam state_t S_RESET       = '0;
  localparam state_t S_LOAD        = state_t'(1 << LOAD_ID);
  localparam state_t S_COMMIT_WAIT = state_t'(1 << COMMIT_WAIT_ID);
  localparam state_t S_COPY        = state_t'(1 << COPY_ID);

endpackage

// File: rtl/coeff_bank.sv
// rtl/coeff_bank.sv - TAPS x WIDTH synchronous RAM, one write port, one registered read port
module coeff_bank #(
  parameter int PTR   = 9,
  parameter int WIDTH = 16,
  parameter int TAPS  = 512
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [PTR-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [TAPS];

  // Write port and registered read port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/filter_coeff_arb.sv
// rtl/filter_coeff_arb.sv - double-buffered FIR coefficient store with pass-safe bank swap (option: FILTER_COEFF_COPYBACK_EN)
module filter_coeff_arb
  import filter_pkg::*;
(
  input  logic             clk,
  input  logic             rstb,
  input  logic             mux_re,
  input  logic [PTR-1:0]   mux_rdptr,
  output logic [WIDTH-1:0] rf_filter_coeff,
  input  logic             cfg_wr_rts,
  output logic             cfg_wr_rtr,
  input  logic [PTR-1:0]   cfg_wr_addr,
  input  logic [WIDTH-1:0] cfg_wr_data,
  input  logic             cfg_commit,
  output logic             commit_pending,
  output logic             commit_done,
  output logic             bank_sel,
  output logic [PTR:0]     cfg_wr_count
);

  localparam logic [PTR:0] TAPS_CNT = (PTR+1)'(TAPS);

  state_t           state;
  state_t           state_nxt;
  logic             host_we;
  logic             swap;
  logic             cp_re;
  logic             cp_we;
  logic [PTR-1:0]   cp_raddr;
  logic [PTR-1:0]   cp_waddr;
  logic             cp_last;
  logic             done_event;
  logic [WIDTH-1:0] bank_rdata [2];
  logic [WIDTH-1:0] cp_wdata;
  logic             filt_q;
  logic             filt_bank_q;
  logic [WIDTH-1:0] hold_q;

  assign host_we  = cfg_wr_rts & cfg_wr_rtr;
  // A swap may only happen between filter passes, i.e. while the filter is not reading.
  assign swap     = state[COMMIT_WAIT_ID] & ~mux_re;
  assign cp_wdata = bank_rdata[bank_sel];

`ifdef FILTER_COEFF_COPYBACK_EN
  localparam state_t SWAP_TARGET = S_COPY;

  logic [PTR:0] cp_ptr;

  // Copy reads borrow the active bank's read port only when the filter leaves it idle.
  assign cp_re    = state[COPY_ID] & ~mux_re & (cp_ptr != TAPS_CNT);
  assign cp_raddr = cp_ptr[PTR-1:0];
  assign cp_last  = cp_we & (cp_waddr == PTR'(TAPS-1));
  assign done_event = cp_last;

  // Copy pipeline: read at ptr, write the returned word into the shadow bank one cycle later.
  always_ff @(posedge clk) begin
    if (rstb || swap) begin
      cp_ptr   <= '0;
      cp_we    <= 1'b0;
      cp_waddr <= '0;
    end else begin
      if (cp_re) begin
        cp_ptr <= cp_ptr + (PTR+1)'(1);
      end
      cp_we    <= cp_re;
      cp_waddr <= cp_raddr;
    end
  end
`else
  localparam state_t SWAP_TARGET = S_LOAD;

  assign cp_re      = 1'b0;
  assign cp_we      = 1'b0;
  assign cp_raddr   = '0;
  assign cp_waddr   = '0;
  assign cp_last    = 1'b0;
  assign done_event = swap;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a commit outside LOAD is ignored.
  always_comb begin
    state_nxt = state;
    if (state[LOAD_ID]) begin
      if (cfg_commit) begin
        state_nxt = S_COMMIT_WAIT;
      end
    end else if (state[COMMIT_WAIT_ID]) begin
      if (swap) begin
        state_nxt = SWAP_TARGET;
      end
    end else if (state[COPY_ID]) begin
      if (cp_last) begin
        state_nxt = S_LOAD;
      end
    end else begin
      state_nxt = S_LOAD;
    end
  end

  // FSM outputs.
  always_comb begin
    cfg_wr_rtr     = state[LOAD_ID];
    commit_pending = state[COMMIT_WAIT_ID] | state[COPY_ID];
  end

  // Bank selection, host write counter and commit completion pulse.
  always_ff @(posedge clk) begin
    if (rstb) begin
      bank_sel     <= 1'b0;
      cfg_wr_count <= '0;
      commit_done  <= 1'b0;
    end else begin
      commit_done <= done_event;
      if (swap) begin
        bank_sel     <= ~bank_sel;
        cfg_wr_count <= '0;
      end else if (host_we && cfg_wr_count != TAPS_CNT) begin
        cfg_wr_count <= cfg_wr_count + (PTR+1)'(1);
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic BANK_ID = 1'(b);

    logic             is_active;
    logic             we;
    logic [PTR-1:0]   waddr;
    logic [WIDTH-1:0] wdata;
    logic             re;
    logic [PTR-1:0]   raddr;

    // The shadow bank takes host or copy writes; the active bank serves filter and copy reads.
    assign is_active = (bank_sel == BANK_ID);
    assign we        = ~is_active & (host_we | cp_we);
    assign waddr     = cp_we ? cp_waddr : cfg_wr_addr;
    assign wdata     = cp_we ? cp_wdata : cfg_wr_data;
    assign re        = is_active & (mux_re | cp_re);
    assign raddr     = mux_re ? mux_rdptr : cp_raddr;

    coeff_bank #(
      .PTR   (PTR),
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_bank (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (re),
      .raddr (raddr),
      .rdata (bank_rdata[b])
    );
  end

  // Track which cycles carried a filter read so copy traffic never disturbs the held output.
  always_ff @(posedge clk) begin
    if (rstb) begin
      filt_q      <= 1'b0;
      filt_bank_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      filt_q <= mux_re;
      if (mux_re) begin
        filt_bank_q <= bank_sel;
      end
      hold_q <= rf_filter_coeff;
    end
  end

  assign rf_filter_coeff = filt_q ? bank_rdata[filt_bank_q] : hold_q;

endmodule

// File: tb/tb_filter_coeff_arb.sv
// tb/tb_filter_coeff_arb.sv - directed self-checking bench for filter_coeff_arb
module tb_filter_coeff_arb;
  import filter_pkg::*;

  logic             clk = 1'b0;
  logic             rstb;
  logic             mux_re;
  logic [PTR-1:0]   mux_rdptr;
  logic [WIDTH-1:0] rf_filter_coeff;
  logic             cfg_wr_rts;
  logic             cfg_wr_rtr;
  logic [PTR-1:0]   cfg_wr_addr;
  logic [WIDTH-1:0] cfg_wr_data;
  logic             cfg_commit;
  logic             commit_pending;
  logic             commit_done;
  logic             bank_sel;
  logic [PTR:0]     cfg_wr_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  filter_coeff_arb dut (
    .clk             (clk),
    .rstb            (rstb),
    .mux_re          (mux_re),
    .mux_rdptr       (mux_rdptr),
    .rf_filter_coeff (rf_filter_coeff),
    .cfg_wr_rts      (cfg_wr_rts),
    .cfg_wr_rtr      (cfg_wr_rtr),
    .cfg_wr_addr     (cfg_wr_addr),
    .cfg_wr_data     (cfg_wr_data),
    .cfg_commit      (cfg_commit),
    .commit_pending  (commit_pending),
    .commit_done     (commit_done),
    .bank_sel        (bank_sel),
    .cfg_wr_count    (cfg_wr_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat_p(input int a);
    return 16'h4000 | 16'(a);
  endfunction

  function automatic logic [15:0] pat_q(input int a);
    return 16'h8000 | 16'(a);
  endfunction

  task automatic write_word(input int addr, input logic [15:0] data);
    cfg_wr_rts  = 1'b1;
    cfg_wr_addr = PTR'(addr);
    cfg_wr_data = data;
    tick;
    cfg_wr_rts  = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input logic [15:0] exp);
    mux_re    = 1'b1;
    mux_rdptr = PTR'(addr);
    tick;
    mux_re    = 1'b0;
    check_eq(tag, rf_filter_coeff, exp);
  endtask

  task automatic wait_live(input string tag);
`ifdef FILTER_COEFF_COPYBACK_EN
    int n;
    n = 0;
    while (!commit_done && n < 3000) begin
      tick;
      n++;
    end
`endif
    check_eq({tag, "_done"}, commit_done, 1);
    check_eq({tag, "_pend_clr"}, commit_pending, 0);
    check_eq({tag, "_rtr_back"}, cfg_wr_rtr, 1);
  endtask

  task automatic commit_idle(input string tag, input logic exp_sel);
    cfg_commit = 1'b1;
    mux_re     = 1'b0;
    tick;
    cfg_commit = 1'b0;
    check_eq({tag, "_pend"}, commit_pending, 1);
    tick;
    check_eq({tag, "_sel"}, bank_sel, exp_sel);
    check_eq({tag, "_cnt_clr"}, cfg_wr_count, 0);
    wait_live(tag);
  endtask

  initial begin
    rstb        = 1'b1;
    mux_re      = 1'b0;
    mux_rdptr   = '0;
    cfg_wr_rts  = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    cfg_commit  = 1'b0;

    // 1: reset values, LOAD one cycle after release
    repeat (3) tick;
    check_eq("t1_rtr_rst", cfg_wr_rtr, 0);
    check_eq("t1_sel_rst", bank_sel, 0);
    check_eq("t1_rf_rst", rf_filter_coeff, 0);
    check_eq("t1_pend_rst", commit_pending, 0);
    check_eq("t1_done_rst", commit_done, 0);
    check_eq("t1_cnt_rst", cfg_wr_count, 0);
    rstb = 1'b0;
    tick;
    check_eq("t1_rtr_load", cfg_wr_rtr, 1);

    // 2: single write, commit while idle, read back from new active bank
    write_word(5, 16'h1234);
    check_eq("t2_cnt1", cfg_wr_count, 1);
    commit_idle("t2", 1'b1);
    read_check("t2_rd5", 5, 16'h1234);
    tick;
    check_eq("t2_hold", rf_filter_coeff, 16'h1234);

    // 3: fill bank0 with P, make it active; fill bank1 with Q; commit during a full pass
    cfg_wr_rts = 1'b1;
    for (int a = 0; a < TAPS; a++) begin
      cfg_wr_addr = PTR'(a);
      cfg_wr_data = pat_p(a);
      tick;
    end
    cfg_wr_rts = 1'b0;
    check_eq("t3_cnt_full", cfg_wr_count, 512);
    commit_idle("t3a", 1'b0);
    cfg_wr_rts = 1'b1;
    for (int a = 0; a < TAPS; a++) begin
      cfg_wr_addr = PTR'(a);
      cfg_wr_data = pat_q(a);
      tick;
    end
    cfg_wr_rts = 1'b0;
    check_eq("t3_cnt_512", cfg_wr_count, 512);
    write_word(0, pat_q(0));
    check_eq("t3_cnt_sat", cfg_wr_count, 512);
    cfg_commit = 1'b1;
    mux_re     = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      mux_rdptr = PTR'(i);
      tick;
      cfg_commit = 1'b0;
      check_eq("t3_pass_rd", rf_filter_coeff, pat_p(i));
    end
    check_eq("t3_sel_held", bank_sel, 0);
    check_eq("t3_pend_held", commit_pending, 1);
    mux_re = 1'b0;
    tick;
    check_eq("t3_sel_swap", bank_sel, 1);
    check_eq("t3_cnt_clr", cfg_wr_count, 0);
    wait_live("t3b");
    read_check("t3_rd0", 0, pat_q(0));
    read_check("t3_rd511", 511, pat_q(511));

    // 4: write and commit in the same cycle
    cfg_wr_rts  = 1'b1;
    cfg_wr_addr = PTR'(9);
    cfg_wr_data = 16'h7FFF;
    cfg_commit  = 1'b1;
    tick;
    cfg_wr_rts = 1'b0;
    cfg_commit = 1'b0;
    check_eq("t4_cnt1", cfg_wr_count, 1);
    check_eq("t4_pend", commit_pending, 1);
    check_eq("t4_rtr_low", cfg_wr_rtr, 0);
    tick;
    check_eq("t4_sel", bank_sel, 0);
    check_eq("t4_cnt0", cfg_wr_count, 0);
    wait_live("t4");
    read_check("t4_rd9", 9, 16'h7FFF);
`ifdef FILTER_COEFF_COPYBACK_EN
    read_check("t4_rd10", 10, pat_q(10));
`else
    read_check("t4_rd10", 10, pat_p(10));
`endif

`ifdef FILTER_COEFF_COPYBACK_EN
    // 5: partial update with copy-back while the filter reads every other cycle
    begin
      int n;
      int rtr_bad;
      write_word(7, 16'h0777);
      cfg_commit = 1'b1;
      tick;
      cfg_commit = 1'b0;
      tick;
      check_eq("t5_sel", bank_sel, 1);
      n       = 0;
      rtr_bad = 0;
      while (!commit_done && n < 3000) begin
        mux_re    = n[0];
        mux_rdptr = '0;
        tick;
        if (cfg_wr_rtr && !commit_done) rtr_bad++;
        n++;
      end
      mux_re = 1'b0;
      check_eq("t5_done", commit_done, 1);
      check_eq("t5_rtr_low", rtr_bad, 0);
      check_eq("t5_copy_len", (n >= 1000), 1);
      read_check("t5_rd5", 5, pat_q(5));
      read_check("t5_rd7", 7, 16'h0777);
      read_check("t5_rd9", 9, 16'h7FFF);
    end
`endif

    // 6: reset during COMMIT_WAIT (and during COPY when present)
`ifndef FILTER_COEFF_COPYBACK_EN
    commit_idle("t6_pre", 1'b1);
`endif
    cfg_commit = 1'b1;
    mux_re     = 1'b1;
    tick;
    cfg_commit = 1'b0;
    tick;
    check_eq("t6_pend_cw", commit_pending, 1);
    check_eq("t6_sel_cw", bank_sel, 1);
    rstb = 1'b1;
    tick;
    mux_re = 1'b0;
    check_eq("t6_pend_rst", commit_pending, 0);
    check_eq("t6_sel_rst", bank_sel, 0);
    check_eq("t6_done_rst", commit_done, 0);
    check_eq("t6_rtr_rst", cfg_wr_rtr, 0);
    rstb = 1'b0;
    tick;
    check_eq("t6_rtr_load", cfg_wr_rtr, 1);
    check_eq("t6_pend_load", commit_pending, 0);
    check_eq("t6_done_load", commit_done, 0);
`ifdef FILTER_COEFF_COPYBACK_EN
    cfg_commit = 1'b1;
    tick;
    cfg_commit = 1'b0;
    tick;
    check_eq("t6c_sel", bank_sel, 1);
    repeat (10) tick;
    check_eq("t6c_pend", commit_pending, 1);
    rstb = 1'b1;
    tick;
    check_eq("t6c_pend_rst", commit_pending, 0);
    check_eq("t6c_sel_rst", bank_sel, 0);
    check_eq("t6c_done_rst", commit_done, 0);
    rstb = 1'b0;
    tick;
    check_eq("t6c_rtr_load", cfg_wr_rtr, 1);
    check_eq("t6c_done_load", commit_done, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
